pooling: RTL and testbench

Streaming 2×2 max-pooling block, stride 2, for the CNN accelerator datapath after the conv/activation stage. It accepts one 16-bit feature-map pixel per valid cycle, in raster order (row-major), and emits one pooled value per 2×2 window. The block buffers half a row internally, so it needs no frame storage.

---
 rtl/pool_pkg.sv | 23 ++
 rtl/pool_line_buf.sv | 25 ++
 rtl/pooling.sv | 82 ++++++++
 tb/tb_pooling.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared defaults and helpers for the 2x2 stride-2 max-pooling block.
package pool_pkg;

    localparam int unsigned IMG_W_DEF = 24;
    localparam int unsigned IMG_H_DEF = 20;
    localparam int unsigned DW_DEF    = 16;

    localparam int unsigned COL_W = $clog2(IMG_W_DEF);
    localparam int unsigned ROW_W = $clog2(IMG_H_DEF);

    // Widest operand max_u handles; callers zero-extend and truncate.
    localparam int unsigned MAX_DW = 64;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_DW-1:0] max_u(input logic [MAX_DW-1:0] a,
                                                input logic [MAX_DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer: synchronous write, combinational read.
module pool_line_buf #(
    parameter int unsigned DEPTH = 12,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pooling.sv
// Streaming 2x2 stride-2 max pooling over a raster-order pixel stream.
module pooling
    import pool_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          Rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          valid_in,
    output logic [DW-1:0] result,
    output logic          valid_out
);

    localparam int unsigned CW = cnt_w(IMG_W);
    localparam int unsigned RW = cnt_w(IMG_H);
    localparam int unsigned AW = cnt_w(IMG_W / 2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] hold;
    logic [DW-1:0] hmax;
    logic [DW-1:0] win_max;
    logic [DW-1:0] lb_rdata;
    logic [AW-1:0] lb_addr;
    logic          lb_we;
    logic          col_last;
    logic          row_last;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col >> 1);

    assign hmax    = DW'(max_u(MAX_DW'(hold), MAX_DW'(s_data)));
    assign win_max = DW'(max_u(MAX_DW'(lb_rdata), MAX_DW'(hmax)));

    // Top row of each pair parks its horizontal max until the bottom row arrives.
    assign lb_we = Rst_n & valid_in & col[0] & ~row[0];

    pool_line_buf #(
        .DEPTH (IMG_W / 2),
        .DW    (DW),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hmax),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            result    <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                if (!col[0]) begin
                    hold <= s_data;
                end else if (row[0]) begin
                    result    <= win_max;
                    valid_out <= 1'b1;
                end

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pooling.sv
// Scoreboard bench for pooling: expected window maxima queued as pixels are driven.
module tb_pooling;

    localparam int W  = 24;
    localparam int H  = 20;
    localparam int DW = 16;

    logic          clk      = 1'b0;
    logic          Rst_n    = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] s_data   = '0;
    logic [DW-1:0] result;
    logic          valid_out;

    pooling #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .s_data    (s_data),
        .valid_in  (valid_in),
        .result    (result),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    int unsigned exp_val_q[$];
    int unsigned exp_cyc_q[$];
    int unsigned got_q[$];
    int unsigned img[H][W];

    task automatic check(input string tag, input int unsigned obs, input int unsigned req);
        n_chk++;
        if (obs == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, req, req);
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_val_q.size() == 0) begin
                check("spurious_pulse", exp_val_q.size(), 1);
            end else begin
                check("result", 32'(result), exp_val_q.pop_front());
                check("latency", cyc, exp_cyc_q.pop_front());
                got_q.push_back(32'(result));
            end
        end
    end

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int unsigned pix(input int mode, input int r, input int c, input int hot);
        case (mode)
            0:       return r * W + c;
            1:       return W * H - 1 - (r * W + c);
            default: return (r == hot / 2 && c == hot % 2) ? 32'hFFFF : 0;
        endcase
    endfunction

    task automatic send(input int r, input int c, input int unsigned v);
        @(negedge clk);
        img[r][c] = v;
        s_data    = DW'(v);
        valid_in  = 1'b1;
        if (r % 2 == 1 && c % 2 == 1) begin
            exp_val_q.push_back(max4(img[r-1][c-1], img[r-1][c], img[r][c-1], v));
            exp_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic frame(input int mode, input int hot, input int maxgap, input int limit);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c >= limit) return;
                send(r, c, pix(mode, r, c, hot));
                if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
            end
        end
    endtask

    task automatic drain(input string tag, input int n_exp);
        idle(4);
        check({tag, "_count"}, got_q.size(), n_exp);
        check({tag, "_pending"}, exp_val_q.size(), 0);
    endtask

    task automatic ramp_checks(input string tag);
        check({tag, "_first"}, got_q[0], 25);
        check({tag, "_second"}, got_q[1], 27);
        check({tag, "_row_end"}, got_q[11], 47);
        check({tag, "_next_pair"}, got_q[12], 73);
        check({tag, "_last"}, got_q[119], 479);
    endtask

    initial begin
        int unsigned rest_max;

        repeat (2) @(negedge clk);
        check("reset_valid_out", 32'(valid_out), 0);
        check("reset_result", 32'(result), 0);
        Rst_n = 1'b1;

        frame(0, 0, 0, W * H);
        drain("ramp", 120);
        ramp_checks("ramp");
        got_q.delete();

        frame(1, 0, 0, W * H);
        drain("reverse", 120);
        check("reverse_first", got_q[0], 479);
        check("reverse_second", got_q[1], 477);
        check("reverse_last", got_q[119], 25);
        got_q.delete();

        frame(0, 0, 5, W * H);
        drain("gapped", 120);
        ramp_checks("gapped");
        got_q.delete();

        frame(0, 0, 0, W * H);
        frame(0, 0, 0, W * H);
        drain("b2b", 240);
        ramp_checks("b2b");
        check("b2b_f2_first", got_q[120], 25);
        check("b2b_f2_last", got_q[239], 479);
        got_q.delete();

        frame(0, 0, 0, 100);
        @(negedge clk);
        valid_in = 1'b0;
        Rst_n    = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_valid_out", 32'(valid_out), 0);
            check("midrst_result", 32'(result), 0);
        end
        Rst_n = 1'b1;
        check("midrst_pending", exp_val_q.size(), 0);
        exp_val_q.delete();
        exp_cyc_q.delete();
        got_q.delete();
        frame(0, 0, 0, W * H);
        drain("midrst", 120);
        ramp_checks("midrst");
        got_q.delete();

        for (int hot = 0; hot < 4; hot++) begin
            frame(2, hot, 0, W * H);
            drain("hot", 120);
            check("hot_first", got_q[0], 32'hFFFF);
            rest_max = 0;
            for (int i = 1; i < got_q.size(); i++)
                if (got_q[i] > rest_max) rest_max = got_q[i];
            check("hot_rest", rest_max, 0);
            got_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
